// File: rtl/sipo_dbuf.sv
// Serial-in / parallel-out converter with two ping-pong vector banks.
// A vector closes on its last slot or on last_i. It is presented the cycle after it closes.
module sipo_dbuf #(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [width_p-1:0]           data_i,
    input  logic                         last_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [width_p*depth_p-1:0]   data_o,
    output logic [$clog2(depth_p+1)-1:0] count_o
);

    localparam int ptr_w = $clog2(depth_p);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

    bank_state_t          r_state     [2];
    bank_state_t          w_state_nxt [2];
    logic [cnt_w-1:0]     r_cnt       [2];
    logic [width_p-1:0]   r_mem       [2][depth_p];
    logic [ptr_w-1:0]     r_wr_ptr;
    logic                 r_fill_sel;
    logic                 r_rd_sel;

    logic                       w_ready;
    logic                       w_valid;
    logic                       w_accept;
    logic                       w_close;
    logic                       w_pop;
    logic [width_p*depth_p-1:0] w_data;
    logic [cnt_w-1:0]           w_count;

    // ready_o looks only at registered bank state, so it has no path from ready_i or valid_i.
    assign w_ready  = !(r_state[0] == FULL && r_state[1] == FULL);
    assign w_valid  = (r_state[r_rd_sel] == FULL);
    assign w_accept = valid_i && w_ready;
    assign w_close  = w_accept && ((r_wr_ptr == last_ptr) || last_i);
    assign w_pop    = w_valid && ready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // The fill bank is never FULL while accepting, so a close and a pop always hit different banks.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_accept) begin
            w_state_nxt[r_fill_sel] = w_close ? FULL : FILLING;
        end
        if (w_pop) begin
            w_state_nxt[r_rd_sel] = EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_fill_sel <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_cnt[r_fill_sel] <= cnt_w'(r_wr_ptr) + cnt_w'(1);
                    r_wr_ptr          <= '0;
                    r_fill_sel        <= ~r_fill_sel;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    // NOTE: element storage has no reset; stale slots are masked by count and valid on the output.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_fill_sel][r_wr_ptr] <= data_i;
        end
    end

    always_comb begin
        w_data  = '0;
        w_count = '0;
        if (w_valid) begin
            w_count = r_cnt[r_rd_sel];
            for (int k = 0; k < depth_p; k++) begin
                if (k < int'(r_cnt[r_rd_sel])) begin
                    w_data[k*width_p +: width_p] = r_mem[r_rd_sel][k];
                end
            end
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign data_o  = w_data;
    assign count_o = w_count;

endmodule

// File: tb/tb_sipo_dbuf.sv
// Scoreboard bench for sipo_dbuf (width 8, depth 4): a vector-level model queues expected
// vectors at close time; a negedge monitor compares whatever the DUT presents.
module tb_sipo_dbuf;

    localparam int W = 8;
    localparam int D = 4;

    typedef struct {
        logic [W*D-1:0] data;
        logic [2:0]     cnt;
    } vec_t;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   data_i;
    logic           last_i;
    logic           valid_o;
    logic           ready_i;
    logic [W*D-1:0] data_o;
    logic [2:0]     count_o;

    sipo_dbuf #(.width_p(W), .depth_p(D)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       sb[$];      // vectors closed and not yet consumed by the monitor
    logic [7:0] cur[$];     // elements of the vector being filled
    int         pending = 0;  // closed vectors not yet popped, as the model sees it

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] exp_data, input logic [2:0] exp_cnt);
        check({name, ".data"}, data_o, exp_data);
        check({name, ".count"}, 32'(count_o), 32'(exp_cnt));
    endtask

    // Model: a vector is the list of accepted elements, packed little-endian, zero above count.
    task automatic close_vector();
        vec_t v;
        v.data = '0;
        for (int k = 0; k < cur.size(); k++) v.data = v.data | (32'(cur[k]) << (8 * k));
        v.cnt = 3'(cur.size());
        sb.push_back(v);
        pending++;
        cur.delete();
    endtask

    // One cycle: drive at posedge+1, check handshake outputs against the model, advance.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic rdy);
        logic m_ready, m_valid, acc, pop;
        valid_i = v;
        data_i  = d;
        last_i  = l;
        ready_i = rdy;
        m_ready = (pending < 2);
        m_valid = (pending > 0);
        check("ready_o", 32'(ready_o), 32'(m_ready));
        check("valid_o", 32'(valid_o), 32'(m_valid));
        acc = v && m_ready;
        pop = m_valid && rdy;
        @(posedge clk_i);
        if (acc) begin
            cur.push_back(d);
            if (l || cur.size() == D) close_vector();
        end
        if (pop) pending--;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #3;
        reset_i = 1'b1;
        #1;
        check("rst.valid_o", 32'(valid_o), 0);
        check("rst.ready_o", 32'(ready_o), 1);
        check("rst.count_o", 32'(count_o), 0);
        check("rst.data_o", data_o, 0);
        sb.delete();
        cur.delete();
        pending = 0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    // Monitor: whatever is presented must match the oldest closed vector; idle output is zero.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 1);
                end else begin
                    check("mon.data", data_o, sb[0].data);
                    check("mon.count", 32'(count_o), 32'(sb[0].cnt));
                    if (ready_i) void'(sb.pop_front());
                end
            end else begin
                check("idle.data", data_o, 0);
                check("idle.count", 32'(count_o), 0);
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        last_i  = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        do_reset();

        // Fill one vector with no consumer
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill.valid", 32'(valid_o), 1);
        check_out("fill", 32'h04030201, 3'd4);

        // Second vector fills both banks; output must hold the first
        for (int i = 5; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("bp.ready_low", 32'(ready_o), 0);
        check_out("bp.hold", 32'h04030201, 3'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_out("bp.next", 32'h08070605, 3'd4);
        check("bp.ready_back", 32'(ready_o), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Early close via last_i
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        check_out("early", 32'h0000BBAA, 3'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset discards a partial vector
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        check_out("rstfill", 32'h66554433, 3'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming at one element per cycle
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 4)  check_out("stream0", 32'h04030201, 3'd4);
            if (i == 8)  check_out("stream1", 32'h08070605, 3'd4);
            if (i == 12) check_out("stream2", 32'h0C0B0A09, 3'd4);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with random backpressure and early closes
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 15),
                 ($urandom_range(99) < 50));
        end

        // Drain with a bounded budget
        for (int i = 0; i < 20 && pending > 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("drain.pending", 32'(pending), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("drain.sb", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
